// File: rtl/sc_spi_slv.sv
// SPI target engine: 2-flop pad sync, CPOL/CPHA modes 0-3, MSB/LSB first. Optional SC_SPI_SLV_MISO_OE_EN adds SPI_MISO_OE.
// Latency: pad edges act at the 3rd SYSCLK edge; RXVALID rises the cycle after the final sample edge.
// Backpressure: RXVALID holds until RXACK (overflow drops the word and pulses RXOVR); TXLOAD ignored while TXFULL.
module sc_spi_slv #(
  parameter int  DW_MAX = 32,
  localparam int CW     = $clog2(DW_MAX)
) (
  input  logic              SYSCLK,
  input  logic              SYSRST,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              BORDER,
  input  logic [CW-1:0]     DWIDTH,
  input  logic [DW_MAX-1:0] TXDATA,
  input  logic              TXLOAD,
  output logic              TXFULL,
  output logic              TXUNDER,
  output logic [DW_MAX-1:0] RXDATA,
  output logic              RXVALID,
  input  logic              RXACK,
  output logic              RXOVR,
  output logic              SPIBUSY,
  output logic              SPICOMPLETE,
  output logic              SPIABORT,
  input  logic              SPI_CSB,
  input  logic              SPI_SCLK,
  input  logic              SPI_MOSI,
`ifdef SC_SPI_SLV_MISO_OE_EN
  output logic              SPI_MISO_OE,
`endif
  output logic              SPI_MISO
);

  typedef enum logic {sIDLE, sSHIFT} state_t;

  state_t            state, state_nxt;
  logic              csb_s1, csb_s2, csb_d;
  logic              sclk_s1, sclk_s2, sclk_d;
  logic              mosi_s1, mosi_s2;
  logic              cpol_q, cpha_q, border_q;
  logic [CW-1:0]     dwidth_q;
  logic [CW-1:0]     bit_cnt;
  logic              skip_q;
  logic [DW_MAX-1:0] tx_sh, rx_sh, txbuf;

  logic              csb_fall, csb_rise, sclk_rise, sclk_fall;
  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic              start, stop, smp, shf, word_done, word_load, txload_ok;
  logic [CW-1:0]     rx_idx;
  logic [DW_MAX-1:0] rx_word_nxt, tx_shifted;

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      csb_s1  <= 1'b1;
      csb_s2  <= 1'b1;
      csb_d   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      csb_s1  <= SPI_CSB;
      csb_s2  <= csb_s1;
      csb_d   <= csb_s2;
      sclk_s1 <= SPI_SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= SPI_MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign csb_fall    = csb_d & ~csb_s2;
  assign csb_rise    = ~csb_d & csb_s2;
  assign sclk_rise   = sclk_s2 & ~sclk_d;
  assign sclk_fall   = ~sclk_s2 & sclk_d;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) state <= sIDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    smp       = 1'b0;
    shf       = 1'b0;
    case (state)
      sIDLE: begin
        if (csb_fall) begin
          state_nxt = sSHIFT;
          start     = 1'b1;
        end
      end
      sSHIFT: begin
        // A CSB rise wins over any SCLK edge seen in the same cycle.
        if (csb_rise) begin
          state_nxt = sIDLE;
          stop      = 1'b1;
        end else begin
          smp = sample_edge;
          shf = shift_edge;
        end
      end
      default: state_nxt = sIDLE;
    endcase
  end

  assign word_done = smp & (bit_cnt == dwidth_q);
  assign word_load = start | word_done;
  assign txload_ok = TXLOAD & (~TXFULL | word_load);
  assign rx_idx    = border_q ? bit_cnt : dwidth_q - bit_cnt;
  assign tx_shifted = border_q ? {1'b1, tx_sh[DW_MAX-1:1]} : {tx_sh[DW_MAX-2:0], 1'b1};

  always_comb begin
    rx_word_nxt         = rx_sh;
    rx_word_nxt[rx_idx] = mosi_s2;
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      border_q    <= 1'b0;
      dwidth_q    <= '0;
      bit_cnt     <= '0;
      skip_q      <= 1'b0;
      tx_sh       <= '1;
      rx_sh       <= '0;
      txbuf       <= '0;
      TXFULL      <= 1'b0;
      TXUNDER     <= 1'b0;
      RXDATA      <= '0;
      RXVALID     <= 1'b0;
      RXOVR       <= 1'b0;
      SPICOMPLETE <= 1'b0;
      SPIABORT    <= 1'b0;
    end else begin
      TXUNDER     <= 1'b0;
      RXOVR       <= 1'b0;
      SPICOMPLETE <= 1'b0;
      SPIABORT    <= 1'b0;

      if (start) begin
        cpol_q   <= CPOL;
        cpha_q   <= CPHA;
        border_q <= BORDER;
        dwidth_q <= DWIDTH;
        bit_cnt  <= '0;
        skip_q   <= CPHA;
      end

      if (word_load) begin
        tx_sh   <= TXFULL ? txbuf : '1;
        TXUNDER <= ~TXFULL;
        rx_sh   <= '0;
      end

      if (txload_ok) begin
        txbuf  <= TXDATA;
        TXFULL <= 1'b1;
      end else if (word_load) begin
        TXFULL <= 1'b0;
      end

      // After a mid-stream reload the next shift edge belongs to the old word's
      // last bit (CPHA=0) or the new word's first bit (CPHA=1); skip it either way.
      if (smp) begin
        if (word_done) begin
          bit_cnt <= '0;
          skip_q  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          rx_sh   <= rx_word_nxt;
        end
      end

      if (shf) begin
        if (skip_q) skip_q <= 1'b0;
        else        tx_sh  <= tx_shifted;
      end

      if (word_done) begin
        if (~RXVALID | RXACK) begin
          RXDATA  <= rx_word_nxt;
          RXVALID <= 1'b1;
        end else begin
          RXOVR <= 1'b1;
        end
      end else if (RXACK) begin
        RXVALID <= 1'b0;
      end

      if (stop) begin
        SPICOMPLETE <= 1'b1;
        SPIABORT    <= |bit_cnt;
        bit_cnt     <= '0;
      end
    end
  end

  assign SPIBUSY  = (state == sSHIFT);
  assign SPI_MISO = (state == sSHIFT) ? (border_q ? tx_sh[0] : tx_sh[dwidth_q]) : 1'b1;

`ifdef SC_SPI_SLV_MISO_OE_EN
  assign SPI_MISO_OE = SPIBUSY;
`endif

endmodule

// File: tb/tb_sc_spi_slv.sv
// Directed bench for sc_spi_slv: a bit-banged SPI master drives the pads while a
// monitor scoreboards RX words and status pulses against queued expectations.
`timescale 1ns/1ps
module tb_sc_spi_slv;
  localparam int DW_MAX = 32;
  localparam int CW     = 5;
  localparam int HALF   = 8;

  logic              SYSCLK = 1'b0;
  logic              SYSRST;
  logic              CPOL, CPHA, BORDER;
  logic [CW-1:0]     DWIDTH;
  logic [DW_MAX-1:0] TXDATA;
  logic              TXLOAD;
  logic              TXFULL, TXUNDER;
  logic [DW_MAX-1:0] RXDATA;
  logic              RXVALID, RXACK, RXOVR;
  logic              SPIBUSY, SPICOMPLETE, SPIABORT;
  logic              SPI_CSB, SPI_SCLK, SPI_MOSI, SPI_MISO;
`ifdef SC_SPI_SLV_MISO_OE_EN
  logic              SPI_MISO_OE;
`endif

  sc_spi_slv #(.DW_MAX(DW_MAX)) dut (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .CPOL(CPOL), .CPHA(CPHA), .BORDER(BORDER),
    .DWIDTH(DWIDTH), .TXDATA(TXDATA), .TXLOAD(TXLOAD), .TXFULL(TXFULL), .TXUNDER(TXUNDER),
    .RXDATA(RXDATA), .RXVALID(RXVALID), .RXACK(RXACK), .RXOVR(RXOVR), .SPIBUSY(SPIBUSY),
    .SPICOMPLETE(SPICOMPLETE), .SPIABORT(SPIABORT), .SPI_CSB(SPI_CSB), .SPI_SCLK(SPI_SCLK),
    .SPI_MOSI(SPI_MOSI),
`ifdef SC_SPI_SLV_MISO_OE_EN
    .SPI_MISO_OE(SPI_MISO_OE),
`endif
    .SPI_MISO(SPI_MISO)
  );

  always #5 SYSCLK = ~SYSCLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rx_q[$];
  logic        exp_cmp_q[$];
  int          exp_ovr_n = 0;
  int          exp_under_n = 0;
  logic        auto_ack = 1'b1;
  logic        rxv_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note(input string name, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: unexpected pulse at %0t", name, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a word or pulse.
  initial begin
    rxv_prev = 1'b0;
    RXACK    = 1'b0;
    forever begin
      @(negedge SYSCLK);
      if (RXVALID && !rxv_prev) begin
        if (exp_rx_q.size() == 0) note("rxvalid", 1'b0);
        else chk("rxdata", RXDATA, exp_rx_q.pop_front());
      end
      rxv_prev = RXVALID;
      if (RXOVR) begin
        note("rxovr", exp_ovr_n > 0);
        if (exp_ovr_n > 0) exp_ovr_n--;
      end
      if (TXUNDER) begin
        note("txunder", exp_under_n > 0);
        if (exp_under_n > 0) exp_under_n--;
      end
      if (SPICOMPLETE) begin
        if (exp_cmp_q.size() == 0) note("spicomplete", 1'b0);
        else chk("spiabort", {31'd0, SPIABORT}, {31'd0, exp_cmp_q.pop_front()});
      end else if (SPIABORT) begin
        note("spiabort_alone", 1'b0);
      end
      RXACK = auto_ack && RXVALID && !RXACK;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  task automatic tx_load(input logic [31:0] d);
    TXDATA = d;
    TXLOAD = 1'b1;
    @(negedge SYSCLK);
    TXLOAD = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic ord, input int dw);
    CPOL     = pol;
    CPHA     = pha;
    BORDER   = ord;
    DWIDTH   = CW'(dw);
    SPI_SCLK = pol;
    cycles(4);
  endtask

  task automatic csb_low();
    SPI_CSB = 1'b0;
    cycles(HALF);
  endtask

  task automatic csb_high();
    cycles(HALF);
    SPI_CSB = 1'b1;
    cycles(2 * HALF);
  endtask

  // Master side: clocks nbits of mosi_w and checks the MISO bits seen at its sample edges.
  task automatic spi_word(input logic [31:0] mosi_w, input logic [31:0] exp_miso,
                          input int nbits, input string name);
    logic [31:0] obs, msk;
    int pos;
    obs = '0;
    msk = '0;
    for (int i = 0; i < nbits; i++) begin
      pos = BORDER ? i : int'(DWIDTH) - i;
      if (!CPHA) begin
        SPI_MOSI = mosi_w[pos];
        cycles(HALF);
        obs[pos] = SPI_MISO;
        msk[pos] = 1'b1;
        SPI_SCLK = ~CPOL;
        cycles(HALF);
        SPI_SCLK = CPOL;
      end else begin
        SPI_SCLK = ~CPOL;
        SPI_MOSI = mosi_w[pos];
        cycles(HALF);
        obs[pos] = SPI_MISO;
        msk[pos] = 1'b1;
        SPI_SCLK = CPOL;
        cycles(HALF);
      end
    end
    chk(name, obs, exp_miso & msk);
  endtask

  initial begin
    SYSRST = 1'b1;
    CPOL = 1'b0; CPHA = 1'b0; BORDER = 1'b0; DWIDTH = 5'd7;
    TXDATA = '0; TXLOAD = 1'b0;
    SPI_CSB = 1'b1; SPI_SCLK = 1'b0; SPI_MOSI = 1'b0;
    cycles(4);
    SYSRST = 1'b0;
    cycles(4);
    chk("rst_txfull", {31'd0, TXFULL}, 32'd0);
    chk("rst_rxvalid", {31'd0, RXVALID}, 32'd0);
    chk("rst_rxdata", RXDATA, 32'd0);
    chk("rst_spibusy", {31'd0, SPIBUSY}, 32'd0);
    chk("rst_miso", {31'd0, SPI_MISO}, 32'd1);
    chk("rst_pulses", {28'd0, TXUNDER, RXOVR, SPICOMPLETE, SPIABORT}, 32'd0);

    // Mode 0, MSB first, 8 bits; second TXLOAD while full must be ignored.
    set_mode(1'b0, 1'b0, 1'b0, 7);
    tx_load(32'hA5);
    chk("t1_txfull", {31'd0, TXFULL}, 32'd1);
    tx_load(32'h77);
    exp_rx_q.push_back(32'h3C); exp_under_n += 1; exp_cmp_q.push_back(1'b0);
    csb_low();
    chk("t1_busy", {31'd0, SPIBUSY}, 32'd1);
    chk("t1_txfull_consumed", {31'd0, TXFULL}, 32'd0);
    spi_word(32'h3C, 32'hA5, 8, "t1_miso");
    csb_high();
    chk("t1_idle_miso", {31'd0, SPI_MISO}, 32'd1);

    // Mode 3, LSB first, 16 bits.
    set_mode(1'b1, 1'b1, 1'b1, 15);
    tx_load(32'h1234);
    exp_rx_q.push_back(32'hBEEF); exp_under_n += 1; exp_cmp_q.push_back(1'b0);
    csb_low();
    spi_word(32'hBEEF, 32'h1234, 16, "t2_miso");
    csb_high();
    set_mode(1'b0, 1'b0, 1'b0, 7);

    // Back-to-back words without RXACK: second word overflows.
    auto_ack = 1'b0;
    tx_load(32'h5A);
    exp_rx_q.push_back(32'h81); exp_ovr_n += 1; exp_under_n += 1; exp_cmp_q.push_back(1'b0);
    csb_low();
    tx_load(32'hC3);
    spi_word(32'h81, 32'h5A, 8, "t3_miso_w1");
    spi_word(32'h7E, 32'hC3, 8, "t3_miso_w2");
    csb_high();
    chk("t3_rxdata_kept", RXDATA, 32'h81);
    chk("t3_rxvalid_held", {31'd0, RXVALID}, 32'd1);
    auto_ack = 1'b1;
    cycles(4);
    chk("t3_rxvalid_acked", {31'd0, RXVALID}, 32'd0);

    // Empty TX buffer: underrun at start and end, MISO all ones.
    exp_rx_q.push_back(32'h5A); exp_under_n += 2; exp_cmp_q.push_back(1'b0);
    csb_low();
    spi_word(32'h5A, 32'hFF, 8, "t4_miso");
    csb_high();

    // CSB rises after 5 bits, then a full word restarts at bit 0.
    tx_load(32'hF0);
    exp_cmp_q.push_back(1'b1);
    csb_low();
    spi_word(32'h3C, 32'hF0, 5, "t5_miso_partial");
    csb_high();
    chk("t5_no_rxvalid", {31'd0, RXVALID}, 32'd0);
    exp_rx_q.push_back(32'hA3); exp_under_n += 2; exp_cmp_q.push_back(1'b0);
    csb_low();
    spi_word(32'hA3, 32'hFF, 8, "t5_miso_full");
    csb_high();

    // Reset mid-word, then a clean mode 1 transfer.
    exp_under_n += 1;
    csb_low();
    spi_word(32'hFF, 32'hFF, 4, "t6_miso_partial");
    tx_load(32'h42);
    chk("t6_txfull_pre", {31'd0, TXFULL}, 32'd1);
    SYSRST = 1'b1;
    @(negedge SYSCLK);
    chk("t6_rst_busy", {31'd0, SPIBUSY}, 32'd0);
    chk("t6_rst_miso", {31'd0, SPI_MISO}, 32'd1);
    chk("t6_rst_txfull", {31'd0, TXFULL}, 32'd0);
    chk("t6_rst_rxdata", RXDATA, 32'd0);
    chk("t6_rst_rxvalid", {31'd0, RXVALID}, 32'd0);
    SYSRST  = 1'b0;
    SPI_CSB = 1'b1;
    set_mode(1'b0, 1'b1, 1'b0, 7);
    tx_load(32'h6D);
    exp_rx_q.push_back(32'hC5); exp_under_n += 1; exp_cmp_q.push_back(1'b0);
    csb_low();
    spi_word(32'hC5, 32'h6D, 8, "t6_miso");
    csb_high();
    cycles(8);

    chk("rx_pending", exp_rx_q.size(), 32'd0);
    chk("cmp_pending", exp_cmp_q.size(), 32'd0);
    chk("ovr_pending", exp_ovr_n, 32'd0);
    chk("under_pending", exp_under_n, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
